// File: rtl/fetch_unit_if.sv
// Fetch front-end bus: core redirect, instruction memory port
// and the decode-side valid/ready instruction stream.
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fsm_err;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready,
    output fsm_err
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready,
    input  fsm_err
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32 instruction fetch: one outstanding word read at a time,
// responses buffered in a small FIFO toward decode.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DROP = 3'd3
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  logic [2:0]    state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   req_pc_q;
  logic          fsm_err_q;
  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          redir;
  logic          rsp;
  logic          hs;
  logic          push;
  logic          pop;
  logic          head_valid;

  assign redir      = bus.redirect_valid;
  assign rsp        = bus.imem_rsp_valid;
  assign hs         = (state_q == REQ) && bus.imem_req_ready;
  assign push       = (state_q == WAIT) && rsp && !redir;
  assign head_valid = (cnt_q != '0);
  assign pop        = head_valid && bus.inst_ready;

  // Occupancy after this cycle's push/pop, ignoring a flush.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      fsm_err_q  <= 1'b0;
    end else begin
      fsm_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (redir || (cnt_q < FULL)) state_q <= REQ;
        end
        REQ: begin
          if (hs) state_q <= redir ? DROP : WAIT;
        end
        WAIT: begin
          if (redir) begin
            state_q <= rsp ? REQ : DROP;
          end else if (rsp) begin
            state_q <= (cnt_d < FULL) ? REQ : IDLE;
          end
        end
        DROP: begin
          if (rsp) state_q <= REQ;
        end
        default: begin
          state_q   <= IDLE;
          fsm_err_q <= 1'b1;
        end
      endcase
      if (hs) req_pc_q <= fetch_pc_q;
      if (redir) begin
        fetch_pc_q <= bus.redirect_pc;
      end else if (hs) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end
    end
  end

  // A redirect flushes everything, including a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (redir) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= '{pc: req_pc_q, data: bus.imem_rsp_data};
        wr_q        <= wr_q + PTR_ONE;
      end
      if (pop) rd_q <= rd_q + PTR_ONE;
      cnt_q <= cnt_d;
    end
  end

  assign bus.imem_req_valid = (state_q == REQ);
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = head_valid;
  assign bus.inst_data      = mem_q[rd_q].data;
  assign bus.inst_pc        = mem_q[rd_q].pc;
  assign bus.fsm_err        = fsm_err_q;
endmodule
